pulse_gap_scheduler: RTL and testbench



---
 rtl/pulse_gap_scheduler_pkg.sv | 22 ++
 rtl/pulse_gap_scheduler_sat_updown_cnt.sv | 51 +++++
 rtl/pulse_gap_scheduler.sv | 119 +++++++++++
 tb/tb_pulse_gap_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_gap_scheduler_pkg.sv
// Shared definitions for the pulse gap scheduler.
//   - pgs_state_e : scheduler FSM states
//   - params_ok   : parameter legality check used at elaboration
//   - max_u       : unsigned maximum helper for sizing timers
package pulse_gap_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StGap   = 2'd2
  } pgs_state_e;

  function automatic bit params_ok(int unsigned gap_cycles, int unsigned pulse_w,
                                   int unsigned cnt_w);
    return (gap_cycles >= 1) && (pulse_w >= 1) && (cnt_w >= 1);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_gap_scheduler_sat_updown_cnt.sv
// Saturating up/down counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i, dec_i  : count up / count down requests (both together cancel)
//   cnt_o         : registered count
//   cnt_d_o       : count value after the coming edge
//   ovf_o         : an increment is being dropped at full scale this cycle
module sat_updown_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_d_o,
  output logic             ovf_o
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CntMax) begin
        ovf_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      // Never wrap below zero even if a stray decrement arrives.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/pulse_gap_scheduler.sv
// Queues single-cycle event strobes and replays each as a clean pulse followed by a
// guaranteed low gap, so a slower destination domain never merges or loses events.
//   clka      : source-domain clock
//   rst_n     : asynchronous active-low reset, discards all queued events
//   evt_in    : event strobe, one event per high cycle
//   en        : launch enable, sampled only while idle
//   ovf_clr   : synchronous clear of the sticky overflow flag
//   pulse_out : spaced pulse, PULSE_W cycles high then GAP_CYCLES low
//   busy      : a pulse/gap is in progress or events are pending
//   pending   : queued, not-yet-launched events
//   ovf       : sticky, an event was dropped at saturation
module pulse_gap_scheduler
  import pulse_gap_scheduler_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned PULSE_W    = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             evt_in,
  input  logic             en,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  if (!params_ok(GAP_CYCLES, PULSE_W, CNT_W)) begin : g_bad_params
    $error("pulse_gap_scheduler: GAP_CYCLES, PULSE_W and CNT_W must all be >= 1");
  end

  localparam int unsigned TmrW = $clog2(max_u(GAP_CYCLES, PULSE_W) + 1);
  localparam logic [TmrW-1:0] PulseLast = TmrW'(PULSE_W - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(GAP_CYCLES - 1);

  pgs_state_e      state_q;
  logic [TmrW-1:0] tmr_q;
  logic            pulse_q, busy_q, ovf_q;

  logic             launch;
  logic             cnt_drop;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_nz_d;

  assign launch    = (state_q == StIdle) && en && (pend_q != '0);
  assign pend_nz_d = (pend_d != '0);

  sat_updown_cnt #(
    .Width (CNT_W)
  ) u_pending (
    .clk_i   (clka),
    .rst_ni  (rst_n),
    .inc_i   (evt_in),
    .dec_i   (launch),
    .cnt_o   (pend_q),
    .cnt_d_o (pend_d),
    .ovf_o   (cnt_drop)
  );

  // Outputs are written alongside the state so they always match the state being entered.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // A drop in the same cycle as a clear keeps the flag set.
      ovf_q <= cnt_drop | (ovf_q & ~ovf_clr);
      case (state_q)
        StIdle: begin
          if (launch) begin
            state_q <= StPulse;
            tmr_q   <= '0;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= pend_nz_d;
          end
        end
        StPulse: begin
          busy_q <= 1'b1;
          if (tmr_q == PulseLast) begin
            state_q <= StGap;
            tmr_q   <= '0;
            pulse_q <= 1'b0;
          end else begin
            tmr_q   <= tmr_q + 1'b1;
          end
        end
        StGap: begin
          if (tmr_q == GapLast) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            busy_q  <= pend_nz_d;
          end else begin
            tmr_q   <= tmr_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tmr_q   <= '0;
          pulse_q <= 1'b0;
          busy_q  <= pend_nz_d;
        end
      endcase
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_gap_scheduler.sv
module tb_pulse_gap_scheduler;

  logic       clka = 1'b0;
  logic       rst_n;
  logic       evt_in;
  logic       en;
  logic       ovf_clr;
  logic       pulse_out;
  logic       busy;
  logic [3:0] pending;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  int npulse, first_p, last_p, min_per, max_pend;

  pulse_gap_scheduler #(
    .GAP_CYCLES (16),
    .PULSE_W    (1),
    .CNT_W      (4)
  ) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .evt_in    (evt_in),
    .en        (en),
    .ovf_clr   (ovf_clr),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: the start of the next cycle.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Runs n cycles, driving evt_in high for the first evt_len of them. Cycle 0 is the
  // cycle in progress at the call; pulses are reported by the cycle index they occupy.
  task automatic run(input int evt_len, input int n, output int np, output int first,
                     output int last, output int minper, output int maxp);
    logic prev;
    prev   = pulse_out;
    np     = 0;
    first  = -1;
    last   = -1;
    minper = 1 << 30;
    maxp   = int'(pending);
    for (int i = 0; i < n; i++) begin
      evt_in = (i < evt_len);
      tick();
      if (pulse_out && !prev) begin
        if (last >= 0 && (i + 1 - last) < minper) minper = i + 1 - last;
        if (first < 0) first = i + 1;
        last = i + 1;
        np++;
      end
      prev = pulse_out;
      if (int'(pending) > maxp) maxp = int'(pending);
    end
    evt_in = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    evt_in  = 1'b0;
    en      = 1'b1;
    ovf_clr = 1'b0;
    #12;
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // 1: single event
    evt_in = 1'b1;
    tick();                                   // cycle 1
    evt_in = 1'b0;
    chk("t1_pend_c1", int'(pending), 1);
    chk("t1_busy_c1", int'(busy), 1);
    chk("t1_pulse_c1", int'(pulse_out), 0);
    tick();                                   // cycle 2
    chk("t1_pulse_c2", int'(pulse_out), 1);
    chk("t1_pend_c2", int'(pending), 0);
    tick();                                   // cycle 3
    chk("t1_pulse_c3", int'(pulse_out), 0);
    for (int i = 0; i < 15; i++) tick();      // cycle 18
    chk("t1_busy_c18", int'(busy), 1);
    tick();                                   // cycle 19
    chk("t1_busy_c19", int'(busy), 0);
    tick();

    // 2: three back-to-back events
    run(3, 60, npulse, first_p, last_p, min_per, max_pend);
    chk("t2_npulse", npulse, 3);
    chk("t2_first", first_p, 2);
    chk("t2_last", last_p, 38);
    chk("t2_period", min_per, 18);
    chk("t2_maxpend", max_pend, 2);

    // 3: saturation, overflow and clear
    run(17, 17, npulse, first_p, last_p, min_per, max_pend);
    chk("t3_pend_sat", int'(pending), 15);
    chk("t3_ovf", int'(ovf), 1);
    run(0, 330, npulse, first_p, last_p, min_per, max_pend);
    chk("t3_npulse_rest", npulse, 15);
    chk("t3_period", min_per, 18);
    chk("t3_ovf_sticky", int'(ovf), 1);
    chk("t3_idle", int'(busy), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);

    // 4: events held back by en=0
    en = 1'b0;
    run(5, 10, npulse, first_p, last_p, min_per, max_pend);
    chk("t4_npulse_off", npulse, 0);
    chk("t4_pend", int'(pending), 5);
    chk("t4_busy", int'(busy), 1);
    en = 1'b1;
    run(0, 100, npulse, first_p, last_p, min_per, max_pend);
    chk("t4_first", first_p, 1);
    chk("t4_npulse", npulse, 5);
    chk("t4_period", min_per, 18);

    // 5: reset during GAP with queued events and ovf set
    en = 1'b0;
    run(16, 18, npulse, first_p, last_p, min_per, max_pend);
    en = 1'b1;
    tick();
    tick();
    chk("t5_pre_pend", int'(pending), 14);
    chk("t5_pre_busy", int'(busy), 1);
    chk("t5_pre_ovf", int'(ovf), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pulse", int'(pulse_out), 0);
    chk("t5_rst_pend", int'(pending), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ovf", int'(ovf), 0);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    run(0, 50, npulse, first_p, last_p, min_per, max_pend);
    chk("t5_no_pulse", npulse, 0);
    chk("t5_post_pend", int'(pending), 0);

    // 6: event coinciding with launch at full scale
    en = 1'b0;
    run(15, 16, npulse, first_p, last_p, min_per, max_pend);
    chk("t6_pre_pend", int'(pending), 15);
    en     = 1'b1;
    evt_in = 1'b1;
    tick();
    chk("t6_pend", int'(pending), 15);
    chk("t6_ovf", int'(ovf), 0);
    chk("t6_pulse", int'(pulse_out), 1);
    // drop and clear in the same cycle: set wins
    ovf_clr = 1'b1;
    tick();
    evt_in = 1'b0;
    chk("t6_set_wins", int'(ovf), 1);
    tick();
    ovf_clr = 1'b0;
    chk("t6_clr", int'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
